sclk_generator: RTL and testbench
=================================

Name: sclk_generator

Overview:
- Parametrised successor to the SPI controller's fixed 8-pulse serial clock divider.
- Generates a burst of N serial clock pulses from i_clk. N, the divisor and the clock polarity are set through a single config strobe.
- Provides leading/trailing edge strobes so the shift engine can sample and launch data without re-deriving edges from o_clk.
- Sits between the SPI control FSM and the pad driver for SCLK.

Parameters:
- DIV_WIDTH, 8, width of the divisor field; max divisor 2^DIV_WIDTH-1.
- CNT_WIDTH, 3, width of the pulse-count field; burst length range 1..2^CNT_WIDTH.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_cfg_valid  in  1  one-cycle strobe; latches i_divisor, i_num_bits, i_cpol.
- i_divisor  in  DIV_WIDTH  system clocks per SCLK period.
- i_num_bits  in  CNT_WIDTH  pulses per burst; value 0 means 2^CNT_WIDTH.
- i_cpol  in  1  idle level of o_clk.
- i_start_n  in  1  active-low start request, level-sampled.
- o_ready  out  1  high when idle and able to accept start or config.
- o_clk  out  1  serial clock.
- o_lead_edge  out  1  one-cycle pulse in the cycle o_clk leaves the idle level.
- o_trail_edge  out  1  one-cycle pulse in the cycle o_clk returns to the idle level.

Behaviour:
- Reset (i_rst high at a posedge i_clk): all effects appear after that edge; reset wins over all other inputs.
  - Reset values: state=IDLE, o_ready=1, o_clk=0, o_lead_edge=0, o_trail_edge=0.
  - Latched config resets to divisor=2, num_bits=0 (i.e. 2^CNT_WIDTH), cpol=0.
  - Reset mid-burst aborts at once; no trailing strobe is emitted.
- Config:
  - i_cfg_valid is accepted only in IDLE; it is ignored while RUN.
  - New config takes effect from the next cycle. If cpol changes, o_clk moves to the new idle level on that same next cycle.
  - If i_cfg_valid and a start request arrive in the same IDLE cycle, the config is latched first and the burst uses the new values.
- Divisor arithmetic:
  - half = latched_divisor >> 1. An odd divisor is rounded down to even.
  - A divisor of 0, 1, 2 or 3 gives half = 1 (fastest rate, i_clk/2).
  - All o_clk registers are flopped; no combinational path from any input to o_clk.
- States: IDLE, RUN.
- IDLE:
  - o_ready=1, o_clk=cpol, strobes low.
  - If i_start_n=0 at a posedge, go to RUN. o_ready=0 from the next cycle.
- RUN:
  - A half-period counter counts from 0 to half-1.
  - On wrap, o_clk toggles and the toggle counter increments. o_clk stays at the idle level for the first half period after start.
  - The toggle that leaves cpol asserts o_lead_edge; the toggle that returns to cpol asserts o_trail_edge. Both strobes are high in the same cycle as the new o_clk value.
  - After 2N toggles (the last is a trailing edge), the next cycle returns to IDLE with o_ready=1.
- Latency: o_ready is low for exactly N*2*half consecutive cycles. Example: divisor=250, N=8 gives 2000 cycles.
- Start held low across completion: o_ready is high for exactly one cycle, then a new burst starts.
- i_start_n changes during RUN are ignored.

Optional Feature:
- Macro SCLK_ABORT_EN.
- Defined:
  - Adds input port i_abort (1 bit, active-high, level), placed after i_start_n.
  - i_abort high in RUN sets a sticky abort flag.
  - If o_clk is at cpol, the burst ends at the end of the current half period; no further lead strobe is issued.
  - If o_clk is active, the burst ends on the next trailing edge; o_trail_edge is asserted there.
  - The cycle after termination is IDLE with o_ready=1. The flag clears on entering IDLE.
  - i_abort is ignored in IDLE.
  - A truncated pulse never appears on o_clk.
- Not defined: no i_abort port; every burst runs to completion.

Test Plan:
- Reset: hold i_rst high for 16 cycles mid-burst, then release -> o_ready=1, o_clk=0, strobes 0 on the first cycle after reset. The latched divisor is 2: a start gives o_ready low for 16 cycles with default N=8.
- Rates: configure divisor 250, 100, 4, 2 with num_bits=0 and cpol=0, then start each -> o_ready low for exactly 2000, 800, 32 and 16 cycles respectively. Each burst has exactly 8 o_lead_edge and 8 o_trail_edge pulses, and ends with o_clk=0.
- Odd divisor and width: divisor=5, num_bits=3 -> half=2, o_ready low for 12 cycles, 3 pulses with a 4-cycle period.
- Polarity: cpol=1, divisor=4, num_bits=1 -> o_clk idles high. One low pulse of 2 cycles; o_lead_edge in the cycle o_clk falls, o_trail_edge in the cycle it rises; o_ready low for 4 cycles.
- Config ignored while busy: pulse i_cfg_valid with divisor=2 during a divisor=100 burst -> that burst still lasts 800 cycles. The following burst also uses divisor=100.
- Abort (SCLK_ABORT_EN): divisor=4, N=8; assert i_abort one cycle after the 3rd o_lead_edge -> burst ends on the 3rd o_trail_edge. o_ready returns high the next cycle; total lead and trail strobe count is 3 each.

Source files
------------

// File: rtl/sclk_generator.sv
// -----------------------------------------------------------------------------
// sclk_generator
//
// Purpose:
//   Generates a burst of N serial clock pulses from i_clk for the SPI shift
//   engine. The divisor, burst length and idle polarity are latched through a
//   single config strobe. One-cycle strobes mark the edges where o_clk leaves
//   the idle level and where it returns to it, so the shift engine does not
//   have to re-derive edges from o_clk.
//
// Optional feature macro: SCLK_ABORT_EN
//   When defined, the module gets an i_abort input that ends a running burst
//   cleanly. A partial pulse never appears on o_clk.
//
// Parameters:
//   DIV_WIDTH : width of the divisor field (max divisor 2^DIV_WIDTH-1), >= 2
//   CNT_WIDTH : width of the pulse-count field (burst length 1..2^CNT_WIDTH)
//
// Ports:
//   i_clk        system clock
//   i_rst        synchronous reset, active-high
//   i_cfg_valid  one-cycle strobe, latches i_divisor/i_num_bits/i_cpol (IDLE only)
//   i_divisor    system clocks per SCLK period (odd values rounded down)
//   i_num_bits   pulses per burst, 0 means 2^CNT_WIDTH
//   i_cpol       idle level of o_clk
//   i_start_n    active-low start request, level-sampled
//   i_abort      (SCLK_ABORT_EN only) active-high abort request, level
//   o_ready      high when idle and able to accept start or config
//   o_clk        serial clock (registered)
//   o_lead_edge  pulse in the cycle o_clk leaves the idle level
//   o_trail_edge pulse in the cycle o_clk returns to the idle level
// -----------------------------------------------------------------------------
module sclk_generator #(
  parameter int DIV_WIDTH = 8,
  parameter int CNT_WIDTH = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_cfg_valid,
  input  logic [DIV_WIDTH-1:0] i_divisor,
  input  logic [CNT_WIDTH-1:0] i_num_bits,
  input  logic                 i_cpol,
  input  logic                 i_start_n,
`ifdef SCLK_ABORT_EN
  input  logic                 i_abort,
`endif
  output logic                 o_ready,
  output logic                 o_clk,
  output logic                 o_lead_edge,
  output logic                 o_trail_edge
);

  // Toggle counter must hold up to 2 * 2^CNT_WIDTH.
  localparam int TOG_W = CNT_WIDTH + 2;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO  = {DIV_WIDTH{1'b0}};
  localparam logic [DIV_WIDTH-1:0] DIV_ONE   = {{(DIV_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = {{(DIV_WIDTH-2){1'b0}}, 2'b10};
  localparam logic [TOG_W-1:0]     TOG_ZERO  = {TOG_W{1'b0}};
  localparam logic [TOG_W-1:0]     TOG_ONE   = {{(TOG_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t               r_state,    w_state_nx;
  logic [DIV_WIDTH-1:0] r_div,      w_div_nx;
  logic [CNT_WIDTH-1:0] r_nbits,    w_nbits_nx;
  logic                 r_cpol,     w_cpol_nx;
  logic [DIV_WIDTH-1:0] r_half_cnt, w_half_cnt_nx;
  logic [TOG_W-1:0]     r_tog_cnt,  w_tog_cnt_nx;
  logic                 r_clk,      w_clk_nx;
  logic                 r_lead,     w_lead_nx;
  logic                 r_trail,    w_trail_nx;
  logic                 r_ready,    w_ready_nx;
  logic                 r_abort,    w_abort_nx;

  logic [DIV_WIDTH-1:0] w_half_raw;
  logic [DIV_WIDTH-1:0] w_half;
  logic [CNT_WIDTH:0]   w_nbits_full;
  logic [TOG_W-1:0]     w_last_tog;
  logic                 w_wrap;
  logic                 w_abort_now;

  // Derived burst timing from the latched config.
  always_comb begin
    w_half_raw = r_div >> 1;
    // Divisors 0 and 1 would give a zero half period; clamp to the fastest rate.
    if (w_half_raw == DIV_ZERO) begin
      w_half = DIV_ONE;
    end else begin
      w_half = w_half_raw;
    end
    if (r_nbits == {CNT_WIDTH{1'b0}}) begin
      w_nbits_full = {1'b1, {CNT_WIDTH{1'b0}}};
    end else begin
      w_nbits_full = {1'b0, r_nbits};
    end
    // Index of the final (trailing) toggle: 2N-1.
    w_last_tog = {w_nbits_full, 1'b0} - TOG_ONE;
    w_wrap     = (r_half_cnt == (w_half - DIV_ONE));
`ifdef SCLK_ABORT_EN
    w_abort_now = r_abort | i_abort;
`else
    w_abort_now = 1'b0;
`endif
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nx    = r_state;
    w_div_nx      = r_div;
    w_nbits_nx    = r_nbits;
    w_cpol_nx     = r_cpol;
    w_half_cnt_nx = r_half_cnt;
    w_tog_cnt_nx  = r_tog_cnt;
    w_clk_nx      = r_clk;
    w_lead_nx     = 1'b0;
    w_trail_nx    = 1'b0;
    w_ready_nx    = r_ready;
    w_abort_nx    = r_abort;

    case (r_state)
      ST_IDLE: begin
        w_half_cnt_nx = DIV_ZERO;
        w_tog_cnt_nx  = TOG_ZERO;
        w_abort_nx    = 1'b0;
        // Config is latched before start is considered, so a same-cycle
        // start runs with the new values and the new idle level.
        if (i_cfg_valid) begin
          w_div_nx   = i_divisor;
          w_nbits_nx = i_num_bits;
          w_cpol_nx  = i_cpol;
          w_clk_nx   = i_cpol;
        end else begin
          w_clk_nx   = r_cpol;
        end
        if (!i_start_n) begin
          w_state_nx = ST_RUN;
          w_ready_nx = 1'b0;
        end else begin
          w_ready_nx = 1'b1;
        end
      end

      ST_RUN: begin
        w_ready_nx = 1'b0;
        w_abort_nx = w_abort_now;
        if (w_wrap) begin
          w_half_cnt_nx = DIV_ZERO;
          if (r_clk == r_cpol) begin
            // Leaving idle level: an abort here ends the burst without
            // starting another pulse.
            if (w_abort_now) begin
              w_state_nx = ST_IDLE;
              w_ready_nx = 1'b1;
              w_abort_nx = 1'b0;
            end else begin
              w_clk_nx     = ~r_clk;
              w_lead_nx    = 1'b1;
              w_tog_cnt_nx = r_tog_cnt + TOG_ONE;
            end
          end else begin
            // Returning to idle level always completes the current pulse.
            w_clk_nx     = ~r_clk;
            w_trail_nx   = 1'b1;
            w_tog_cnt_nx = r_tog_cnt + TOG_ONE;
            if ((r_tog_cnt == w_last_tog) || w_abort_now) begin
              w_state_nx = ST_IDLE;
              w_ready_nx = 1'b1;
              w_abort_nx = 1'b0;
            end else begin
              w_state_nx = ST_RUN;
            end
          end
        end else begin
          w_half_cnt_nx = r_half_cnt + DIV_ONE;
        end
      end

      default: begin
        w_state_nx = ST_IDLE;
        w_ready_nx = 1'b1;
        w_clk_nx   = r_cpol;
        w_abort_nx = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_div      <= DIV_RESET;
      r_nbits    <= {CNT_WIDTH{1'b0}};
      r_cpol     <= 1'b0;
      r_half_cnt <= DIV_ZERO;
      r_tog_cnt  <= TOG_ZERO;
      r_clk      <= 1'b0;
      r_lead     <= 1'b0;
      r_trail    <= 1'b0;
      r_ready    <= 1'b1;
      r_abort    <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_div      <= w_div_nx;
      r_nbits    <= w_nbits_nx;
      r_cpol     <= w_cpol_nx;
      r_half_cnt <= w_half_cnt_nx;
      r_tog_cnt  <= w_tog_cnt_nx;
      r_clk      <= w_clk_nx;
      r_lead     <= w_lead_nx;
      r_trail    <= w_trail_nx;
      r_ready    <= w_ready_nx;
      r_abort    <= w_abort_nx;
    end
  end

  assign o_ready      = r_ready;
  assign o_clk        = r_clk;
  assign o_lead_edge  = r_lead;
  assign o_trail_edge = r_trail;

endmodule

// File: tb/tb_sclk_generator.sv
// -----------------------------------------------------------------------------
// tb_sclk_generator
//
// Directed self-checking bench for sclk_generator (DIV_WIDTH=8, CNT_WIDTH=3).
// Inputs change and outputs are sampled on the falling edge of i_clk.
// Define SCLK_ABORT_EN for both RTL and bench to exercise the abort port.
// -----------------------------------------------------------------------------
module tb_sclk_generator;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cfg_valid = 1'b0;
  logic [7:0] i_divisor = 8'd0;
  logic [2:0] i_num_bits = 3'd0;
  logic       i_cpol = 1'b0;
  logic       i_start_n = 1'b1;
`ifdef SCLK_ABORT_EN
  logic       i_abort = 1'b0;
`endif
  logic       o_ready;
  logic       o_clk;
  logic       o_lead_edge;
  logic       o_trail_edge;

  int total = 0;
  int bad   = 0;

  always #5 i_clk = ~i_clk;

  sclk_generator #(.DIV_WIDTH(8), .CNT_WIDTH(3)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cfg_valid  (i_cfg_valid),
    .i_divisor    (i_divisor),
    .i_num_bits   (i_num_bits),
    .i_cpol       (i_cpol),
    .i_start_n    (i_start_n),
`ifdef SCLK_ABORT_EN
    .i_abort      (i_abort),
`endif
    .o_ready      (o_ready),
    .o_clk        (o_clk),
    .o_lead_edge  (o_lead_edge),
    .o_trail_edge (o_trail_edge)
  );

  // Apply a one-cycle config strobe.
  task automatic do_cfg(input int div, input int nb, input logic pol);
    i_divisor   = div[7:0];
    i_num_bits  = nb[2:0];
    i_cpol      = pol;
    i_cfg_valid = 1'b1;
    @(negedge i_clk);
    i_cfg_valid = 1'b0;
  endtask

  // Start one burst and measure it. cfg_at>0 pulses a divisor=2 config at that
  // busy cycle; abort_lead>0 raises i_abort once that many leads were seen.
  task automatic run_burst(input int cfg_at, input int abort_lead,
                           output int low, output int leads, output int trails,
                           output int first_lead, output int last_lead,
                           output logic first_lead_clk, output logic end_clk);
    low = 0; leads = 0; trails = 0; first_lead = 0; last_lead = 0;
    first_lead_clk = 1'bx;
    i_start_n = 1'b0;
    @(negedge i_clk);
    i_start_n = 1'b1;
    for (int k = 0; k < 5000 && o_ready == 1'b0; k++) begin
      low++;
      if (o_lead_edge) begin
        leads++;
        if (first_lead == 0) begin
          first_lead     = low;
          first_lead_clk = o_clk;
        end
        last_lead = low;
      end
      if (o_trail_edge) trails++;
      if (cfg_at != 0 && low == cfg_at) begin
        i_divisor   = 8'd2;
        i_cfg_valid = 1'b1;
      end else begin
        i_cfg_valid = 1'b0;
      end
`ifdef SCLK_ABORT_EN
      if (abort_lead != 0 && leads >= abort_lead) i_abort = 1'b1;
`endif
      @(negedge i_clk);
    end
    i_cfg_valid = 1'b0;
`ifdef SCLK_ABORT_EN
    i_abort = 1'b0;
`endif
    // The final trailing strobe coincides with the first ready cycle.
    if (o_lead_edge) leads++;
    if (o_trail_edge) trails++;
    end_clk = o_clk;
  endtask

  task automatic test_reset();
    int low, leads, trails, fl, ll;
    logic flc, ec;
    i_rst = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    total++; if (o_clk !== 1'b0) begin bad++; $display("FAIL reset_clk got=%b exp=0", o_clk); end
    total++; if (o_lead_edge !== 1'b0 || o_trail_edge !== 1'b0) begin
      bad++; $display("FAIL reset_strobes got=%b%b exp=00", o_lead_edge, o_trail_edge);
    end
    do_cfg(100, 0, 1'b1);
    total++; if (o_clk !== 1'b1) begin bad++; $display("FAIL cpol_idle_applied got=%b exp=1", o_clk); end
    i_start_n = 1'b0;
    @(negedge i_clk);
    i_start_n = 1'b1;
    repeat (50) @(negedge i_clk);
    i_rst = 1'b1;
    repeat (16) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    total++; if (o_ready !== 1'b1 || o_clk !== 1'b0 || o_lead_edge !== 1'b0 || o_trail_edge !== 1'b0) begin
      bad++; $display("FAIL midburst_reset got rdy=%b clk=%b l=%b t=%b exp 1 0 0 0",
                      o_ready, o_clk, o_lead_edge, o_trail_edge);
    end
    run_burst(0, 0, low, leads, trails, fl, ll, flc, ec);
    total++; if (low !== 16) begin bad++; $display("FAIL reset_default_len got=%0d exp=16", low); end
    total++; if (leads !== 8 || trails !== 8) begin
      bad++; $display("FAIL reset_default_edges got=%0d/%0d exp=8/8", leads, trails);
    end
  endtask

  task automatic test_rates();
    int divs[4] = '{250, 100, 4, 2};
    int lows[4] = '{2000, 800, 32, 16};
    int fls[4]  = '{126, 51, 3, 2};
    int lls[4]  = '{1876, 751, 31, 16};
    int low, leads, trails, fl, ll;
    logic flc, ec;
    for (int i = 0; i < 4; i++) begin
      do_cfg(divs[i], 0, 1'b0);
      run_burst(0, 0, low, leads, trails, fl, ll, flc, ec);
      total++; if (low !== lows[i]) begin bad++; $display("FAIL rate_len div=%0d got=%0d exp=%0d", divs[i], low, lows[i]); end
      total++; if (leads !== 8 || trails !== 8) begin
        bad++; $display("FAIL rate_edges div=%0d got=%0d/%0d exp=8/8", divs[i], leads, trails);
      end
      total++; if (fl !== fls[i] || ll !== lls[i]) begin
        bad++; $display("FAIL rate_lead_pos div=%0d got=%0d/%0d exp=%0d/%0d", divs[i], fl, ll, fls[i], lls[i]);
      end
      total++; if (ec !== 1'b0) begin bad++; $display("FAIL rate_end_clk div=%0d got=%b exp=0", divs[i], ec); end
    end
  endtask

  task automatic test_odd_divisor();
    int low, leads, trails, fl, ll;
    logic flc, ec;
    do_cfg(5, 3, 1'b0);
    run_burst(0, 0, low, leads, trails, fl, ll, flc, ec);
    total++; if (low !== 12) begin bad++; $display("FAIL odd_len got=%0d exp=12", low); end
    total++; if (leads !== 3 || trails !== 3) begin
      bad++; $display("FAIL odd_edges got=%0d/%0d exp=3/3", leads, trails);
    end
    total++; if (fl !== 3 || ll !== 11) begin bad++; $display("FAIL odd_period got=%0d/%0d exp=3/11", fl, ll); end
  endtask

  task automatic test_polarity();
    int low, leads, trails, fl, ll;
    logic flc, ec;
    do_cfg(4, 1, 1'b1);
    total++; if (o_clk !== 1'b1) begin bad++; $display("FAIL pol_idle got=%b exp=1", o_clk); end
    run_burst(0, 0, low, leads, trails, fl, ll, flc, ec);
    total++; if (low !== 4) begin bad++; $display("FAIL pol_len got=%0d exp=4", low); end
    total++; if (leads !== 1 || trails !== 1) begin
      bad++; $display("FAIL pol_edges got=%0d/%0d exp=1/1", leads, trails);
    end
    total++; if (fl !== 3 || flc !== 1'b0) begin
      bad++; $display("FAIL pol_lead_fall got idx=%0d clk=%b exp idx=3 clk=0", fl, flc);
    end
    total++; if (ec !== 1'b1) begin bad++; $display("FAIL pol_end_clk got=%b exp=1", ec); end
  endtask

  task automatic test_cfg_busy();
    int low, leads, trails, fl, ll;
    logic flc, ec;
    do_cfg(100, 0, 1'b0);
    run_burst(10, 0, low, leads, trails, fl, ll, flc, ec);
    total++; if (low !== 800) begin bad++; $display("FAIL busy_cfg_len got=%0d exp=800", low); end
    run_burst(0, 0, low, leads, trails, fl, ll, flc, ec);
    total++; if (low !== 800) begin bad++; $display("FAIL busy_cfg_next_len got=%0d exp=800", low); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    do_cfg(4, 1, 1'b0);
    i_start_n = 1'b0;
    @(negedge i_clk);
    cnt = 0;
    while (o_ready == 1'b0 && cnt < 100) begin cnt++; @(negedge i_clk); end
    total++; if (cnt !== 4) begin bad++; $display("FAIL b2b_first_len got=%0d exp=4", cnt); end
    cnt = 0;
    while (o_ready == 1'b1 && cnt < 100) begin cnt++; @(negedge i_clk); end
    total++; if (cnt !== 1) begin bad++; $display("FAIL b2b_ready_gap got=%0d exp=1", cnt); end
    i_start_n = 1'b1;
    cnt = 0;
    while (o_ready == 1'b0 && cnt < 100) begin cnt++; @(negedge i_clk); end
    total++; if (cnt !== 4) begin bad++; $display("FAIL b2b_second_len got=%0d exp=4", cnt); end
  endtask

`ifdef SCLK_ABORT_EN
  task automatic test_abort();
    int low, leads, trails, fl, ll;
    logic flc, ec;
    do_cfg(4, 0, 1'b0);
    run_burst(0, 3, low, leads, trails, fl, ll, flc, ec);
    total++; if (low !== 12) begin bad++; $display("FAIL abort_len got=%0d exp=12", low); end
    total++; if (leads !== 3 || trails !== 3) begin
      bad++; $display("FAIL abort_edges got=%0d/%0d exp=3/3", leads, trails);
    end
    total++; if (ec !== 1'b0) begin bad++; $display("FAIL abort_end_clk got=%b exp=0", ec); end
  endtask
`endif

  initial begin
    @(negedge i_clk);
    test_reset();
    test_rates();
    test_odd_divisor();
    test_polarity();
    test_cfg_busy();
    test_back_to_back();
`ifdef SCLK_ABORT_EN
    test_abort();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
